// File: rtl/vga_tmds_encoder_if.sv
// vga_tmds_encoder_if: VGA pixel/sync input bus and TMDS symbol output bus
interface vga_tmds_encoder_if;
   logic [3:0] vga_r, vga_g, vga_b;
   logic       vga_hs, vga_vs;
   logic [9:0] tmds_r, tmds_g, tmds_b;
   logic       de_out;
   modport master (output vga_r, vga_g, vga_b, vga_hs, vga_vs, input tmds_r, tmds_g, tmds_b, de_out);
   modport slave (input vga_r, vga_g, vga_b, vga_hs, vga_vs, output tmds_r, tmds_g, tmds_b, de_out);
endinterface

// File: rtl/vga_tmds_encoder.sv
// vga_tmds_encoder: recovers DE from VGA sync timing and DVI-encodes RGB into three 10-bit TMDS symbols
module vga_tmds_encoder #(
   parameter int H_START  = 112,
   parameter int H_ACTIVE = 512,
   parameter int V_START  = 34,
   parameter int V_ACTIVE = 480
) (
   input logic clk,
   input logic reset,
   vga_tmds_encoder_if.slave bus
);
   localparam logic [10:0] h_lo = 11'(H_START);
   localparam logic [10:0] h_hi = 11'(H_START + H_ACTIVE);
   localparam logic [10:0] v_lo = 11'(V_START);
   localparam logic [10:0] v_hi = 11'(V_START + V_ACTIVE);
   function automatic logic [9:0] token(input logic [1:0] c);
      return c == 2'b00 ? 10'b1101010100 : c == 2'b01 ? 10'b0010101011 :
             c == 2'b10 ? 10'b0101010100 : 10'b1010101011;
   endfunction
   function automatic logic [8:0] min_trans(input logic [7:0] d);
      logic x;
      logic [8:0] q;
      x = $countones(d) > 4 || ($countones(d) == 4 && !d[0]);
      q = {~x, 7'd0, d[0]};
      for (int i = 1; i < 8; i++) q[i] = x ? ~(q[i-1] ^ d[i]) : q[i-1] ^ d[i];
      return q;
   endfunction
   logic [3:0] r0, g0, b0;
   logic hs_d, vs_d, locked, h_fall, v_fall, de0;
   logic [9:0] h_cnt, v_cnt;
   logic [2:0][8:0] qm;
   logic de1, hs1, vs1, de2;
   assign h_fall = hs_d & ~bus.vga_hs;
   assign v_fall = vs_d & ~bus.vga_vs;
   assign de0 = locked && {1'b0, h_cnt} >= h_lo && {1'b0, h_cnt} < h_hi &&
                {1'b0, v_cnt} >= v_lo && {1'b0, v_cnt} < v_hi;
   // stage 0: capture pins and track position relative to the latest sync falling edges
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         {r0, g0, b0} <= '0;
         hs_d <= 1'b1;
         vs_d <= 1'b1;
         h_cnt <= '0;
         v_cnt <= '0;
         locked <= 1'b0;
      end else begin
         {r0, g0, b0} <= {bus.vga_r, bus.vga_g, bus.vga_b};
         hs_d <= bus.vga_hs;
         vs_d <= bus.vga_vs;
         h_cnt <= h_fall ? '0 : h_cnt + 10'(h_cnt != '1);
         v_cnt <= v_fall ? '0 : v_cnt + 10'(h_fall && v_cnt != '1);
         locked <= locked | v_fall;
      end
   // stage 1: transition-minimise each expanded colour byte, syncs and DE ride along
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         qm <= '0;
         {de1, hs1, vs1} <= '0;
      end else begin
         qm <= {min_trans({r0, r0}), min_trans({g0, g0}), min_trans({b0, b0})};
         {de1, hs1, vs1} <= {de0, hs_d, vs_d};
      end
   // stage 2: DE delayed to line up with the balanced symbols
   always_ff @(posedge clk or posedge reset)
      if (reset) de2 <= 1'b0;
      else de2 <= de1;
   for (genvar c = 0; c < 3; c++) begin : g_ch
      logic [9:0] sym, sym_nx;
      logic signed [4:0] cnt, cnt_nx, diff;
      logic q8;
      logic [7:0] q;
      assign {q8, q} = qm[c];
      assign diff = 5'(2 * $countones(q) - 8);
      // DC balance: pick the polarity that pulls the running disparity back toward zero
      always_comb begin
         sym_nx = {~q8, q8, q8 ? q : ~q};
         cnt_nx = q8 ? cnt + diff : cnt - diff;
         if (!de1) begin
            sym_nx = token(c == 0 ? {vs1, hs1} : 2'b00);
            cnt_nx = '0;
         end else if (cnt != 5'sd0 && diff != 5'sd0) begin
            if ((cnt > 5'sd0) == (diff > 5'sd0)) begin
               sym_nx = {1'b1, q8, ~q};
               cnt_nx = cnt + 5'({q8, 1'b0}) - diff;
            end else begin
               sym_nx = {1'b0, q8, q};
               cnt_nx = cnt - 5'({~q8, 1'b0}) + diff;
            end
         end
      end
      // symbol and disparity registers
      always_ff @(posedge clk or posedge reset)
         if (reset) begin
            sym <= 10'b1101010100;
            cnt <= '0;
         end else begin
            sym <= sym_nx;
            cnt <= cnt_nx;
         end
   end
   assign bus.tmds_r = g_ch[2].sym;
   assign bus.tmds_g = g_ch[1].sym;
   assign bus.tmds_b = g_ch[0].sym;
   assign bus.de_out = de2;
endmodule

// File: tb/tb_vga_tmds_encoder.sv
// tb_vga_tmds_encoder: directed and scoreboarded checks of DE recovery and TMDS encoding on a shrunken video timing
module tb_vga_tmds_encoder;
   localparam int H0 = 12, HN = 16, V0 = 4, VN = 6, LINE = 42, LINES = 14;
   typedef struct {
      logic de;
      logic [9:0] r, g, b;
      int ln, h;
   } exp_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   vga_tmds_encoder_if bus();
   vga_tmds_encoder #(.H_START(H0), .H_ACTIVE(HN), .V_START(V0), .V_ACTIVE(VN)) dut (
      .clk(clk), .reset(reset), .bus(bus));
   // free-running pixel clock
   always #5 clk = ~clk;
   int n_chk = 0, n_fail = 0;
   exp_t hist [3];
   int m_h, m_v, m_disp [3];
   bit m_hs, m_vs, m_lock;
   int de_n, de_lines, prev_ln, first_ln, first_h, last_ln, last_h, max_disp, o_disp [3];
   logic [9:0] hr [4], hg [4], hb [4];
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic enc(input logic [7:0] d, input bit de, input logic [1:0] c, input int ch, output logic [9:0] s);
      int n1d, n1q, n0q;
      bit use_xnor;
      logic [8:0] q;
      if (!de) begin
         case (c)
            2'b00: s = 10'h354;
            2'b01: s = 10'h0AB;
            2'b10: s = 10'h154;
            default: s = 10'h2AB;
         endcase
         m_disp[ch] = 0;
      end else begin
         n1d = 0;
         for (int i = 0; i < 8; i++) n1d += int'(d[i]);
         use_xnor = n1d > 4 || (n1d == 4 && d[0] == 1'b0);
         q = '0;
         q[0] = d[0];
         for (int i = 1; i < 8; i++) q[i] = use_xnor ? (q[i-1] == d[i]) : (q[i-1] != d[i]);
         q[8] = !use_xnor;
         n1q = 0;
         for (int i = 0; i < 8; i++) n1q += int'(q[i]);
         n0q = 8 - n1q;
         if (m_disp[ch] == 0 || n1q == n0q) begin
            s = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
            m_disp[ch] += q[8] ? n1q - n0q : n0q - n1q;
         end else if ((m_disp[ch] > 0 && n1q > n0q) || (m_disp[ch] < 0 && n0q > n1q)) begin
            s = {1'b1, q[8], ~q[7:0]};
            m_disp[ch] += 2 * int'(q[8]) + n0q - n1q;
         end else begin
            s = {1'b0, q[8], q[7:0]};
            m_disp[ch] += -2 * int'(!q[8]) + n1q - n0q;
         end
      end
   endtask
   task automatic model(input logic [3:0] r, g, b, input logic hs, vs, output exp_t e);
      bit hf, vf;
      hf = m_hs && !hs;
      vf = m_vs && !vs;
      m_h = hf ? 0 : (m_h < 1023 ? m_h + 1 : 1023);
      m_v = vf ? 0 : (hf && m_v < 1023 ? m_v + 1 : m_v);
      m_lock = m_lock || vf;
      m_hs = hs;
      m_vs = vs;
      e.de = m_lock && m_h >= H0 && m_h < H0 + HN && m_v >= V0 && m_v < V0 + VN;
      enc({r, r}, e.de, 2'b00, 2, e.r);
      enc({g, g}, e.de, 2'b00, 1, e.g);
      enc({b, b}, e.de, {vs, hs}, 0, e.b);
      e.ln = 0;
      e.h = 0;
   endtask
   task automatic model_reset();
      m_h = 0;
      m_v = 0;
      m_hs = 1'b1;
      m_vs = 1'b1;
      m_lock = 1'b0;
      for (int c = 0; c < 3; c++) m_disp[c] = 0;
      hist[1] = '{de: 1'b0, r: 10'h354, g: 10'h354, b: 10'h354, ln: -1, h: -1};
      hist[0] = '{de: 1'b0, r: 10'h354, g: 10'h354, b: 10'h2AB, ln: -1, h: -1};
   endtask
   task automatic clear_stats();
      de_n = 0;
      de_lines = 0;
      prev_ln = -1;
      first_ln = -1;
      first_h = -1;
      last_ln = -1;
      last_h = -1;
      max_disp = 0;
      for (int c = 0; c < 3; c++) o_disp[c] = 0;
   endtask
   task automatic observe();
      logic [9:0] sy [3];
      int a;
      sy[0] = bus.tmds_b;
      sy[1] = bus.tmds_g;
      sy[2] = bus.tmds_r;
      if (bus.de_out) begin
         if (de_n < 4) begin
            hr[de_n] = bus.tmds_r;
            hg[de_n] = bus.tmds_g;
            hb[de_n] = bus.tmds_b;
         end
         if (de_n == 0) begin
            first_ln = hist[2].ln;
            first_h = hist[2].h;
         end
         if (hist[2].ln != prev_ln) de_lines++;
         prev_ln = hist[2].ln;
         last_ln = hist[2].ln;
         last_h = hist[2].h;
         de_n++;
      end
      for (int c = 0; c < 3; c++) begin
         o_disp[c] = bus.de_out ? o_disp[c] + 2 * $countones(sy[c]) - 10 : 0;
         a = o_disp[c] < 0 ? -o_disp[c] : o_disp[c];
         if (a > max_disp) max_disp = a;
      end
   endtask
   task automatic step(input logic [3:0] r, g, b, input logic hs, vs, input int ln, input int h);
      exp_t e;
      bus.vga_r = r;
      bus.vga_g = g;
      bus.vga_b = b;
      bus.vga_hs = hs;
      bus.vga_vs = vs;
      model(r, g, b, hs, vs, e);
      e.ln = ln;
      e.h = h;
      @(posedge clk);
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = e;
      @(negedge clk);
      chk("scb", 32'({bus.de_out, bus.tmds_r, bus.tmds_g, bus.tmds_b}),
          32'({hist[2].de, hist[2].r, hist[2].g, hist[2].b}));
      observe();
   endtask
   task automatic px(input int mode, input int ln, input int h);
      logic [3:0] r, g, b;
      r = mode == 2 ? 4'($urandom) : 4'h0;
      g = mode == 2 ? 4'($urandom) : 4'hF;
      b = mode == 2 ? 4'($urandom) : 4'h0;
      step(r, g, b, !(h >= 30 && h <= 37), !(ln == 10 || ln == 11), ln, h);
   endtask
   task automatic lines(input int mode, input int l0, input int l1);
      for (int ln = l0; ln < l1; ln++)
         for (int h = 0; h < LINE; h++) px(mode, ln, h);
   endtask
   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_r", bus.tmds_r, 10'h354);
      chk("rst_g", bus.tmds_g, 10'h354);
      chk("rst_b", bus.tmds_b, 10'h354);
      chk("rst_de", bus.de_out, 0);
      reset = 1'b0;
      model_reset();
   endtask
   task automatic check_frame(input string t);
      chk({t, "_de_count"}, de_n, HN * VN);
      chk({t, "_de_lines"}, de_lines, VN);
      chk({t, "_first_line"}, first_ln, 0);
      chk({t, "_first_h"}, first_h, 0);
      chk({t, "_last_line"}, last_ln, VN - 1);
      chk({t, "_last_h"}, last_h, HN - 1);
      chk({t, "_disp_bound"}, 32'(max_disp <= 10), 1);
   endtask
   initial begin
      logic [9:0] ex_rb [4], ex_g [4];
      ex_rb = '{10'h100, 10'h3FF, 10'h100, 10'h3FF};
      ex_g = '{10'h200, 10'h0FF, 10'h0FF, 10'h200};
      bus.vga_r = 4'h0;
      bus.vga_g = 4'h0;
      bus.vga_b = 4'h0;
      bus.vga_hs = 1'b1;
      bus.vga_vs = 1'b1;
      do_reset();
      clear_stats();
      repeat (20) step(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, -1, -1);
      chk("idle_r", bus.tmds_r, 10'h354);
      chk("idle_g", bus.tmds_g, 10'h354);
      chk("idle_b", bus.tmds_b, 10'h2AB);
      chk("idle_de_count", de_n, 0);
      repeat (4) step(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, -1, -1);
      chk("blk_hs0_vs1_b", bus.tmds_b, 10'h154);
      chk("blk_hs0_vs1_r", bus.tmds_r, 10'h354);
      chk("blk_hs0_vs1_g", bus.tmds_g, 10'h354);
      repeat (4) step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, -1, -1);
      chk("blk_hs0_vs0_b", bus.tmds_b, 10'h354);
      repeat (4) step(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, -1, -1);
      chk("blk_hs1_vs0_b", bus.tmds_b, 10'h0AB);
      repeat (4) step(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, -1, -1);
      chk("blk_hs1_vs1_b", bus.tmds_b, 10'h2AB);
      do_reset();
      clear_stats();
      lines(1, 0, LINES);
      chk("unlocked_de_count", de_n, 0);
      clear_stats();
      lines(1, 0, LINES);
      check_frame("fixed");
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("fixed_r%0d", i), hr[i], ex_rb[i]);
         chk($sformatf("fixed_g%0d", i), hg[i], ex_g[i]);
         chk($sformatf("fixed_b%0d", i), hb[i], ex_rb[i]);
      end
      clear_stats();
      lines(2, 0, LINES);
      check_frame("random");
      lines(2, 0, 2);
      for (int h = 0; h < 6; h++) px(2, 2, h);
      chk("pre_reset_de", bus.de_out, 1);
      #1 reset = 1'b1;
      #1;
      chk("mid_reset_r", bus.tmds_r, 10'h354);
      chk("mid_reset_g", bus.tmds_g, 10'h354);
      chk("mid_reset_b", bus.tmds_b, 10'h354);
      chk("mid_reset_de", bus.de_out, 0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      clear_stats();
      for (int h = 6; h < LINE; h++) px(2, 2, h);
      lines(2, 3, LINES);
      chk("post_reset_de_count", de_n, 0);
      clear_stats();
      lines(2, 0, LINES);
      check_frame("relock");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
